// File: rtl/coupler_pkg.sv
// Shared types and helpers for the Coupler mask path.
package coupler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Widest lane count the keep helper supports; callers cast down to their width.
  localparam int unsigned KEEP_MAX = 64;

  // rem==0 means the final beat is full, otherwise only the low rem lanes carry data.
  function automatic logic [KEEP_MAX-1:0] keep_for_rem(input int unsigned rem,
                                                        input int unsigned num_elements);
    logic [KEEP_MAX-1:0] k;
    int unsigned         n;
    k = '0;
    n = (rem == 0) ? num_elements : rem;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      k[i] = (i < n);
    end
    return k;
  endfunction

endpackage

// File: rtl/coupler_mask_sequencer_credit_counter.sv
// Credit counter mirroring free slots in the Coupler's mask FIFO.
module credit_counter #(
  parameter  int MAX = 8,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          take,
  input  logic          give,
  output logic [CW-1:0] count,
  output logic          available,
  output logic          overflow
);

  logic full;
  logic give_ok;

  assign full      = (count == CW'(MAX));
  assign give_ok   = give && !full;
  assign overflow  = give && full;
  assign available = (count != '0);

  // A return at full credits has no matching issue, so it is dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CW'(MAX);
    end else begin
      case ({take, give_ok})
        2'b10:   count <= count - CW'(1);
        2'b01:   count <= count + CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coupler_mask_sequencer.sv
// Turns element-count descriptors into {keep, last} mask beats for the Coupler,
// throttled by credits so the Coupler's mask FIFO never overflows.
module coupler_mask_sequencer
  import coupler_pkg::*;
#(
  parameter int NUM_ELEMENTS   = 4,
  parameter int MAX_IN_TRANSIT = 8,
  parameter int LEN_BITS       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [LEN_BITS-1:0]   desc_data,
  output logic                  mask_valid,
  output logic [NUM_ELEMENTS:0] mask_data,
  input  logic                  beat_done,
  input  logic                  beat_last,
  output logic                  desc_done,
  output logic                  busy,
  output logic                  err,
  output seq_state_t            state_dbg
);

  localparam int SHIFT = $clog2(NUM_ELEMENTS);
  localparam int RW    = (SHIFT > 0) ? SHIFT : 1;
  localparam int CW    = $clog2(MAX_IN_TRANSIT + 1);

  typedef logic [NUM_ELEMENTS:0] mask_t;

  // Handshakes: desc transfers on a cycle where desc_valid && desc_ready; desc_valid
  // must hold with stable desc_data until then. mask has no ready: every cycle with
  // mask_valid high is consumed, which is why issue is gated by credits.

  seq_state_t            state, next_state;
  logic [LEN_BITS-1:0]   beats_left;
  logic [RW-1:0]         rem;
  logic                  zero_len;
  logic [CW-1:0]         credits;
  logic                  credit_avail;
  logic                  credit_ovf;
  logic                  accept;
  logic                  issue;
  logic                  final_beat;
  logic [LEN_BITS-1:0]   len_beats;
  logic [RW-1:0]         len_rem;
  mask_t                 mask_next;

  assign accept     = desc_valid && desc_ready;
  assign issue      = (state == RUN) && credit_avail;
  assign final_beat = (beats_left == LEN_BITS'(1));
  assign state_dbg  = state;

  // ceil(L/N) via shift plus a carry from the low bits; L=0 still yields one beat.
  always_comb begin
    len_rem   = (SHIFT == 0) ? '0 : desc_data[RW-1:0];
    len_beats = (desc_data >> SHIFT) + LEN_BITS'(|len_rem);
    if (len_beats == '0) len_beats = LEN_BITS'(1);
  end

  credit_counter #(.MAX(MAX_IN_TRANSIT)) u_credits (
    .clk       (clk),
    .rst_n     (rst_n),
    .take      (issue),
    .give      (beat_done),
    .count     (credits),
    .available (credit_avail),
    .overflow  (credit_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (issue && final_beat) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // desc_ready stays low while the final mask is on the wire, leaving one bubble.
  always_comb begin
    desc_ready = (state == IDLE) && !(mask_valid && mask_data[0]);
    mask_next  = {{NUM_ELEMENTS{1'b1}}, 1'b0};
    if (final_beat) begin
      mask_next = zero_len ? mask_t'(1)
                           : {NUM_ELEMENTS'(keep_for_rem(32'(rem), NUM_ELEMENTS)), 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left <= '0;
      rem        <= '0;
      zero_len   <= 1'b0;
    end else if (accept) begin
      beats_left <= len_beats;
      rem        <= len_rem;
      zero_len   <= (desc_data == '0);
    end else if (issue) begin
      beats_left <= beats_left - LEN_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_valid <= 1'b0;
      mask_data  <= '0;
      desc_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      mask_valid <= issue;
      mask_data  <= issue ? mask_next : '0;
      desc_done  <= beat_done && beat_last;
      err        <= err || credit_ovf;
    end
  end

  assign busy = (state == RUN) || (credits != CW'(MAX_IN_TRANSIT));

endmodule

// File: tb/tb_coupler_mask_sequencer.sv
// Self-checking bench for coupler_mask_sequencer with a mask scoreboard.
module tb_coupler_mask_sequencer;
  import coupler_pkg::*;

  localparam int NE  = 4;
  localparam int MIT = 4;
  localparam int LB  = 32;
  localparam int MW  = NE + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [LB-1:0] desc_data = '0;
  logic          mask_valid;
  logic [MW-1:0] mask_data;
  logic          beat_done = 1'b0;
  logic          beat_last = 1'b0;
  logic          desc_done;
  logic          busy;
  logic          err;
  seq_state_t    state_dbg;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int ready_low = 0;
  int done_cnt = 0;
  int mv_cnt = 0;
  int mv_last = 0;
  logic pend_v = 1'b0;
  logic pend_l = 1'b0;
  logic auto_ret = 1'b0;
  logic man_done = 1'b0;
  logic man_last = 1'b0;
  logic [MW-1:0] exp_q[$];

  coupler_mask_sequencer #(
    .NUM_ELEMENTS(NE), .MAX_IN_TRANSIT(MIT), .LEN_BITS(LB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .mask_valid(mask_valid), .mask_data(mask_data),
    .beat_done(beat_done), .beat_last(beat_last),
    .desc_done(desc_done), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc_n);
    end
  endtask

  // Coupler stand-in: returns beat_done one cycle after each mask in auto mode.
  always @(posedge clk) begin
    #2;
    beat_done = auto_ret ? pend_v : man_done;
    beat_last = auto_ret ? pend_l : man_last;
  end

  // monitor + scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      pend_v = 1'b0;
      pend_l = 1'b0;
    end else begin
      if (!desc_ready) ready_low++;
      if (desc_done) done_cnt++;
      if (mask_valid) begin
        mv_last = cyc_n;
        mv_cnt++;
        e = (exp_q.size() > 0) ? 64'(exp_q.pop_front()) : 64'hDEAD;
        chk("mask", 64'(mask_data), e);
      end
      pend_v = mask_valid;
      pend_l = mask_data[0];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int len);
    int n;
    int r;
    logic [NE-1:0] k;
    if (len == 0) begin
      exp_q.push_back({{NE{1'b0}}, 1'b1});
    end else begin
      n = (len + NE - 1) / NE;
      r = len % NE;
      for (int i = 0; i < n - 1; i++) exp_q.push_back({{NE{1'b1}}, 1'b0});
      k = (r == 0) ? {NE{1'b1}} : NE'((1 << r) - 1);
      exp_q.push_back({k, 1'b1});
    end
  endtask

  task automatic send_desc(input int len, output int acc);
    for (int i = 0; i < 100 && !desc_ready; i++) cyc();
    chk("desc_ready_wait", 64'(desc_ready), 1);
    desc_valid = 1'b1;
    desc_data  = LB'(len);
    push_exp(len);
    cyc();
    acc = cyc_n;
    desc_valid = 1'b0;
    desc_data  = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (busy || exp_q.size() != 0); i++) cyc();
    chk("idle_busy", 64'(busy), 0);
  endtask

  task automatic pulse_done(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) begin
      man_done = 1'b1;
      man_last = last_on_final && (i == n - 1);
      cyc();
    end
    man_done = 1'b0;
    man_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, p, b_rl, b_dc, b_mv;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mask_valid", 64'(mask_valid), 0);
    chk("rst_mask_data", 64'(mask_data), 0);
    chk("rst_desc_ready", 64'(desc_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    rst_n = 1'b1;
    cyc();
    chk("rst_desc_done", 64'(desc_done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));

    // L=10: 1111/1111/0011
    auto_ret = 1'b1;
    b_rl = ready_low; b_dc = done_cnt; b_mv = mv_cnt;
    send_desc(10, acc);
    chk("t1_lat0", 64'(mask_valid), 0);
    cyc();
    chk("t1_lat1", 64'(mask_valid), 1);
    wait_idle();
    repeat (3) cyc();
    chk("t1_beats", 64'(mv_cnt - b_mv), 3);
    chk("t1_span", 64'(mv_last - (acc + 1)), 2);
    chk("t1_done", 64'(done_cnt - b_dc), 1);
    chk("t1_ready_low", 64'(ready_low - b_rl), 4);

    // L=8 then L=0
    b_rl = ready_low; b_dc = done_cnt;
    send_desc(8, acc);
    wait_idle();
    repeat (3) cyc();
    chk("t2a_ready_low", 64'(ready_low - b_rl), 3);
    chk("t2a_done", 64'(done_cnt - b_dc), 1);
    b_rl = ready_low; b_dc = done_cnt; b_mv = mv_cnt;
    send_desc(0, acc);
    wait_idle();
    repeat (3) cyc();
    chk("t2b_ready_low", 64'(ready_low - b_rl), 2);
    chk("t2b_done", 64'(done_cnt - b_dc), 1);
    chk("t2b_beats", 64'(mv_cnt - b_mv), 1);

    // L=20 with no returns: stalls after MIT masks
    auto_ret = 1'b0;
    b_dc = done_cnt; b_mv = mv_cnt;
    send_desc(20, acc);
    repeat (10) cyc();
    chk("t3_stall_cnt", 64'(mv_cnt - b_mv), 4);
    chk("t3_stall_valid", 64'(mask_valid), 0);
    chk("t3_stall_busy", 64'(busy), 1);
    chk("t3_state_run", 64'(state_dbg), 64'(RUN));
    p = cyc_n;
    pulse_done(1, 1'b0);
    repeat (4) cyc();
    chk("t3_one_more", 64'(mv_cnt - b_mv), 5);
    chk("t3_resume_lat", 64'(mv_last - p), 2);
    pulse_done(4, 1'b1);
    wait_idle();
    repeat (2) cyc();
    chk("t3_done", 64'(done_cnt - b_dc), 1);
    chk("t3_err", 64'(err), 0);

    // return coinciding with issue at credits=1
    b_dc = done_cnt; b_mv = mv_cnt;
    send_desc(20, acc);
    repeat (3) cyc();
    man_done = 1'b1;
    cyc();
    cyc();
    man_done = 1'b0;
    repeat (3) cyc();
    chk("t4_beats", 64'(mv_cnt - b_mv), 5);
    chk("t4_span", 64'(mv_last - (acc + 1)), 4);
    pulse_done(3, 1'b1);
    wait_idle();
    repeat (2) cyc();
    chk("t4_done", 64'(done_cnt - b_dc), 1);
    chk("t4_err", 64'(err), 0);

    // spurious return sets sticky err
    pulse_done(1, 1'b0);
    cyc();
    chk("t5_err", 64'(err), 1);
    chk("t5_busy", 64'(busy), 0);
    auto_ret = 1'b1;
    b_mv = mv_cnt;
    send_desc(4, acc);
    wait_idle();
    repeat (2) cyc();
    chk("t5_beats", 64'(mv_cnt - b_mv), 1);
    chk("t5_err_sticky", 64'(err), 1);

    // reset mid-transfer
    send_desc(40, acc);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", 64'(mask_valid), 0);
    chk("t6_data", 64'(mask_data), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_ready", 64'(desc_ready), 1);
    chk("t6_err", 64'(err), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_state", 64'(state_dbg), 64'(IDLE));
    b_mv = mv_cnt;
    send_desc(4, acc);
    wait_idle();
    repeat (2) cyc();
    chk("t6_beats", 64'(mv_cnt - b_mv), 1);
    chk("t6_err_after", 64'(err), 0);

    chk("q_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coupler_mask_sequencer.md
# coupler_mask_sequencer

Generates the per-beat mask stream that drives the Coupler. It converts transfer descriptors (element counts) into `{keep, last}` beats and throttles issue with a credit counter. This keeps the Coupler's mask FIFO, which has no back-pressure, from overflowing. It sits beside the Coupler and is fed by the crossbar's transfer scheduler.

## Interface
Parameters:
- `NUM_ELEMENTS`, 4, Coupler lane count; power of two, ≥1.
- `MAX_IN_TRANSIT`, 8, must equal the Coupler's mask FIFO depth; initial credit count.
- `LEN_BITS`, 32, width of the descriptor element count.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `desc` ready_valid_i.s, `LEN_BITS`: transfer descriptor, element count L.
- `mask` valid_i.m, `NUM_ELEMENTS+1`: `{keep[NUM_ELEMENTS-1:0], last}` to the Coupler mask port.
- `beat_done` in 1: Coupler `out.valid && out.ready`.
- `beat_last` in 1: Coupler `out.last`; qualified by `beat_done`.
- `desc_done` out 1: one-cycle pulse per retired descriptor.
- `busy` out 1: a descriptor is being issued, or beats are in flight.
- `err` out 1: sticky; `beat_done` arrived while credits were already full.

## Operation
- FSM states are IDLE and RUN.
- **IDLE**
  - `desc.ready=1`.
  - On handshake, latch beats = max(1, ceil(L/NUM_ELEMENTS)) and rem = L mod NUM_ELEMENTS, then go to RUN.
- **RUN**
  - `desc.ready=0`.
  - While credits>0: issue one mask per cycle, decrement the beats remaining.
  - Non-final beat: keep = all ones, last=0.
  - Final beat: keep = rem==0 ? all ones : (1<<rem)-1, last=1. The FSM returns to IDLE on the same edge.
  - L=0 is a single beat with keep=0, last=1. The Coupler emits an empty terminating beat.
- **Credits**
  - Register of width $clog2(MAX_IN_TRANSIT+1), reset to MAX_IN_TRANSIT.
  - −1 per issued mask, +1 per `beat_done`. Issue and `beat_done` in the same cycle leave it unchanged.
  - `beat_done` at full credits: credits unchanged, `err` set until reset.
- `desc_done` is registered `beat_done && beat_last`.
- `busy` = state==RUN || credits!=MAX_IN_TRANSIT.
- Arithmetic: ceil and mod use shifts and masks only (power-of-two lanes). The beats counter is LEN_BITS wide, so L = 2^LEN_BITS−1 does not overflow.

## Timing
- Reset values: `mask.valid=0`, `mask.data=0`, `desc.ready=1` (IDLE), `desc_done=0`, `busy=0`, `err=0`.
- `mask.valid` and `mask.data` are registered:
  - descriptor accepted at edge t → first mask valid after edge t+1;
  - with credits available, beats are back-to-back every cycle.
- Issue decision uses the registered credit count. A `beat_done` in cycle t enables an issue at edge t+1 when credits were 0.
- One idle bubble between descriptors: `desc.ready` rises the cycle after the final mask is issued.
- `desc_done` is high in the cycle after `beat_done && beat_last`.
- Reset asserted mid-RUN: all outputs clear immediately and asynchronously. In-flight beats are discarded, and the Coupler must be reset on the same `rst_n`.

## Structure
- Shared `coupler_pkg`: `seq_state_t` enum {IDLE, RUN}, plus the `keep_for_rem` function, which takes rem and NUM_ELEMENTS and returns the keep vector.
- `mask_t` stays local because its width depends on NUM_ELEMENTS.
- One sub-module: `credit_counter`, parameterised by MAX; inputs take/give; outputs `available` and `overflow`.

## Test plan
(NUM_ELEMENTS=4, MAX_IN_TRANSIT=4, `beat_done` returned 1 cycle after each mask unless noted)
1. L=10 → 3 consecutive masks keep 1111/1111/0011 with last 0/0/1; one `desc_done` pulse; `busy` low afterwards.
2. L=8 → 2 masks 1111/1111 with last 0/1. Then L=0 → one mask keep 0000, last 1. `desc.ready` low for exactly beats+1 cycles per descriptor.
3. L=20 with `beat_done` held 0 → exactly 4 masks, then `mask.valid` stays 0. One `beat_done` pulse → exactly one more mask 1 cycle later.
4. `beat_done` in the same cycle as an issue at credits=1 → credits stay 1 and issue continues every cycle.
5. `beat_done` with no beats in flight → `err`=1 and stays set; credits remain 4; a following L=4 issues normally.
6. Reset asserted during beat 2 of L=40 → `mask.valid`=0 and `busy`=0 immediately. After release, `desc.ready`=1 and a new L=4 yields a single mask 1111/last=1.
